i2si_bist_chk: RTL and testbench

//  Checker for the I2S-input BIST sawtooth. Consumes 32-bit words plus a transfer-complete strobe, locks onto
//  the start value, predicts each following word from the same start/inc/limit registers that drive the

---
 rtl/i2si_bist_chk.sv | 143 ++++++++++++++
 tb/tb_i2si_bist_chk.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2si_bist_chk.sv
// Checker for the I2S-input BIST sawtooth: locks onto the start word, predicts each following
// word from the generator registers, and counts mismatching and checked words.
module i2si_bist_chk #(
    parameter int CNT_W      = 16,
    parameter int LOSS_ERRS  = 4,
    parameter int SYNC_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic [11:0]      rf_bist_start_val,
    input  logic [7:0]       rf_bist_inc,
    input  logic [11:0]      rf_bist_up_limit,
    input  logic [31:0]      i2si_data,
    input  logic             i2si_xfc,
    output logic             bist_locked,
    output logic             bist_err,
    output logic             bist_sync_fail,
    output logic [CNT_W-1:0] bist_err_cnt,
    output logic [CNT_W-1:0] bist_word_cnt
);

    localparam int CONSEC_W = $clog2(LOSS_ERRS + 1);
    localparam int SYNC_W   = $clog2(SYNC_WORDS + 1);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    state_t              state, state_n;
    logic [15:0]         expected, expected_n;
    logic [CONSEC_W-1:0] consec, consec_n;
    logic [SYNC_W-1:0]   sync_cnt, sync_cnt_n;
    logic                err, err_n;
    logic                sync_fail, sync_fail_n;
    logic [CNT_W-1:0]    err_cnt, err_cnt_n;
    logic [CNT_W-1:0]    word_cnt, word_cnt_n;
    logic [15:0]         start_ext, limit_ext;

    assign start_ext = {{4{rf_bist_start_val[11]}}, rf_bist_start_val};
    assign limit_ext = {{4{rf_bist_up_limit[11]}}, rf_bist_up_limit};

    function automatic logic [15:0] advance(input logic [15:0] v, input logic [15:0] s,
                                            input logic [15:0] l, input logic [7:0] inc);
        return ($signed(v) >= $signed(l)) ? s : v + {8'h00, inc};
    endfunction

    function automatic logic [31:0] word_form(input logic [15:0] v);
        return {~v, v};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            expected  <= '0;
            consec    <= '0;
            sync_cnt  <= '0;
            err       <= 1'b0;
            sync_fail <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= state_n;
            expected  <= expected_n;
            consec    <= consec_n;
            sync_cnt  <= sync_cnt_n;
            err       <= err_n;
            sync_fail <= sync_fail_n;
            err_cnt   <= err_cnt_n;
            word_cnt  <= word_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        expected_n  = expected;
        consec_n    = consec;
        sync_cnt_n  = sync_cnt;
        err_n       = 1'b0;
        sync_fail_n = sync_fail;
        err_cnt_n   = err_cnt;
        word_cnt_n  = word_cnt;
        case (state)
            IDLE: begin
                if (chk_en) begin
                    state_n     = SYNC;
                    err_cnt_n   = '0;
                    word_cnt_n  = '0;
                    sync_fail_n = 1'b0;
                    sync_cnt_n  = '0;
                end
            end
            SYNC: begin
                if (!chk_en) begin
                    state_n = IDLE;
                end else if (i2si_xfc) begin
                    if (i2si_data == word_form(start_ext)) begin
                        state_n    = CHECK;
                        expected_n = advance(start_ext, start_ext, limit_ext, rf_bist_inc);
                        word_cnt_n = CNT_W'(1);
                        consec_n   = '0;
                    end else begin
                        if (sync_cnt != SYNC_W'(SYNC_WORDS))
                            sync_cnt_n = sync_cnt + SYNC_W'(1);
                        if (sync_cnt >= SYNC_W'(SYNC_WORDS - 1))
                            sync_fail_n = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (!chk_en) begin
                    state_n = IDLE;
                end else if (i2si_xfc) begin
                    if (word_cnt != '1)
                        word_cnt_n = word_cnt + CNT_W'(1);
                    if (i2si_data == word_form(expected)) begin
                        expected_n = advance(expected, start_ext, limit_ext, rf_bist_inc);
                        consec_n   = '0;
                    end else begin
                        // re-track from the received sample so a single bad word costs one error
                        err_n      = 1'b1;
                        expected_n = advance(i2si_data[15:0], start_ext, limit_ext, rf_bist_inc);
                        if (err_cnt != '1)
                            err_cnt_n = err_cnt + CNT_W'(1);
                        if (consec >= CONSEC_W'(LOSS_ERRS - 1)) begin
                            state_n    = SYNC;
                            sync_cnt_n = '0;
                            consec_n   = '0;
                        end else begin
                            consec_n = consec + CONSEC_W'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bist_locked    = (state == CHECK);
    assign bist_err       = err;
    assign bist_sync_fail = sync_fail;
    assign bist_err_cnt   = err_cnt;
    assign bist_word_cnt  = word_cnt;

endmodule

// File: tb/tb_i2si_bist_chk.sv
// Bench for i2si_bist_chk: directed sawtooth streams against a word-level model, checked every cycle
// on a full-width and a 4-bit-counter instance.
module tb_i2si_bist_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_en;
    logic [11:0] rf_bist_start_val;
    logic [7:0]  rf_bist_inc;
    logic [11:0] rf_bist_up_limit;
    logic [31:0] i2si_data;
    logic        i2si_xfc;

    logic        bist_locked, bist_err, bist_sync_fail;
    logic [15:0] bist_err_cnt, bist_word_cnt;
    logic        locked_s, err_s, sync_fail_s;
    logic [3:0]  err_cnt_s, word_cnt_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    i2si_bist_chk #(.CNT_W(16), .LOSS_ERRS(4), .SYNC_WORDS(64)) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en),
        .rf_bist_start_val(rf_bist_start_val), .rf_bist_inc(rf_bist_inc),
        .rf_bist_up_limit(rf_bist_up_limit), .i2si_data(i2si_data), .i2si_xfc(i2si_xfc),
        .bist_locked(bist_locked), .bist_err(bist_err), .bist_sync_fail(bist_sync_fail),
        .bist_err_cnt(bist_err_cnt), .bist_word_cnt(bist_word_cnt)
    );

    i2si_bist_chk #(.CNT_W(4), .LOSS_ERRS(4), .SYNC_WORDS(64)) dut_s (
        .clk(clk), .rst(rst), .chk_en(chk_en),
        .rf_bist_start_val(rf_bist_start_val), .rf_bist_inc(rf_bist_inc),
        .rf_bist_up_limit(rf_bist_up_limit), .i2si_data(i2si_data), .i2si_xfc(i2si_xfc),
        .bist_locked(locked_s), .bist_err(err_s), .bist_sync_fail(sync_fail_s),
        .bist_err_cnt(err_cnt_s), .bist_word_cnt(word_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wf(input logic [15:0] v);
        return {~v, v};
    endfunction

    function automatic logic [15:0] start16();
        int s;
        s = int'($signed(rf_bist_start_val));
        return 16'(s);
    endfunction

    // Sawtooth step using plain signed integers.
    function automatic logic [15:0] adv(input logic [15:0] v);
        int l, vi;
        l  = int'($signed(rf_bist_up_limit));
        vi = int'($signed(v));
        if (vi >= l) return start16();
        return 16'(int'(v) + int'(rf_bist_inc));
    endfunction

    function automatic int sat(input int x, input int w);
        int m;
        m = (1 << w) - 1;
        return (x > m) ? m : x;
    endfunction

    // Model: enabled/locked flags, unbounded counts, saturated only when compared.
    bit          m_on, m_lock, m_err, m_sf;
    int          m_errc, m_wordc, m_misses, m_badrun;
    logic [15:0] m_exp;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 0; m_lock = 0; m_err = 0; m_sf = 0;
            m_errc = 0; m_wordc = 0; m_misses = 0; m_badrun = 0;
            m_exp = '0;
        end else begin
            m_err = 0;
            if (!m_on) begin
                if (chk_en) begin
                    m_on = 1; m_lock = 0; m_errc = 0; m_wordc = 0; m_sf = 0; m_misses = 0;
                end
            end else if (!chk_en) begin
                m_on = 0; m_lock = 0;
            end else if (i2si_xfc) begin
                if (!m_lock) begin
                    if (i2si_data == wf(start16())) begin
                        m_lock = 1; m_exp = adv(start16()); m_wordc = 1; m_badrun = 0;
                    end else begin
                        m_misses++;
                        if (m_misses >= 64) m_sf = 1;
                    end
                end else begin
                    m_wordc++;
                    if (i2si_data == wf(m_exp)) begin
                        m_exp = adv(m_exp); m_badrun = 0;
                    end else begin
                        m_err = 1; m_errc++; m_badrun++;
                        m_exp = adv(i2si_data[15:0]);
                        if (m_badrun == 4) begin
                            m_lock = 0; m_misses = 0; m_badrun = 0;
                        end
                    end
                end
            end
        end
        #1;
        check("locked", 32'(bist_locked), 32'(m_lock));
        check("err", 32'(bist_err), 32'(m_err));
        check("sync_fail", 32'(bist_sync_fail), 32'(m_sf));
        check("err_cnt", 32'(bist_err_cnt), sat(m_errc, 16));
        check("word_cnt", 32'(bist_word_cnt), sat(m_wordc, 16));
        check("err_cnt_4b", 32'(err_cnt_s), sat(m_errc, 4));
        check("word_cnt_4b", 32'(word_cnt_s), sat(m_wordc, 4));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [31:0] w);
        @(negedge clk);
        i2si_data = w;
        i2si_xfc  = 1'b1;
        @(negedge clk);
        i2si_xfc  = 1'b0;
    endtask

    task automatic enable();
        @(negedge clk) chk_en = 1'b0;
        @(negedge clk) chk_en = 1'b1;
    endtask

    task automatic set_regs(input logic [11:0] s, input logic [7:0] i, input logic [11:0] l);
        rf_bist_start_val = s;
        rf_bist_inc       = i;
        rf_bist_up_limit  = l;
    endtask

    function automatic logic [15:0] saw(input int k);
        return 16'(16 + 4 * (k % 5));
    endfunction

    initial begin
        rst = 1'b1; chk_en = 1'b0; i2si_data = '0; i2si_xfc = 1'b0;
        set_regs(12'h010, 8'h04, 12'h020);
        idle(3);
        check("rst_locked", 32'(bist_locked), 0);
        check("rst_err_cnt", 32'(bist_err_cnt), 0);
        check("rst_word_cnt", 32'(bist_word_cnt), 0);
        check("rst_sync_fail", 32'(bist_sync_fail), 0);
        rst = 1'b0;
        idle(2);

        // 1: three clean periods of 10,14,18,1C,20
        enable();
        for (int k = 0; k < 15; k++) begin
            xfer(wf(saw(k)));
            if (k == 0) check("t1_lock_first", 32'(bist_locked), 1);
        end
        check("t1_err_cnt", 32'(bist_err_cnt), 0);
        check("t1_word_cnt", 32'(bist_word_cnt), 15);
        @(negedge clk) chk_en = 1'b0;
        idle(1);
        check("t1_idle_unlocked", 32'(bist_locked), 0);
        check("t1_idle_hold", 32'(bist_word_cnt), 15);

        // 2: signed wrap through zero
        set_regs(12'hFF0, 8'h08, 12'h008);
        enable();
        xfer(wf(16'hFFF0)); xfer(wf(16'hFFF8)); xfer(wf(16'h0000));
        xfer(wf(16'h0008)); xfer(wf(16'hFFF0));
        check("t2_err_cnt", 32'(bist_err_cnt), 0);
        check("t2_word_cnt", 32'(bist_word_cnt), 5);
        check("t2_locked", 32'(bist_locked), 1);

        // 3: one word with corrupted upper half, sequence continues
        set_regs(12'h010, 8'h04, 12'h020);
        enable();
        xfer(wf(16'h0010));
        xfer(32'hFFEA_0014);
        check("t3_err_pulse", 32'(bist_err), 1);
        check("t3_err_cnt", 32'(bist_err_cnt), 1);
        xfer(wf(16'h0018));
        check("t3_err_clear", 32'(bist_err), 0);
        check("t3_err_cnt_after", 32'(bist_err_cnt), 1);
        check("t3_locked", 32'(bist_locked), 1);

        // 4: four consecutive bad words drop lock, then relock
        enable();
        xfer(wf(16'h0010));
        for (int k = 1; k <= 4; k++) begin
            xfer(wf(saw(k)) ^ 32'h0001_0000);
            if (k == 3) check("t4_still_locked", 32'(bist_locked), 1);
        end
        check("t4_err_cnt", 32'(bist_err_cnt), 4);
        check("t4_unlocked", 32'(bist_locked), 0);
        xfer(wf(16'h0010));
        check("t4_relock", 32'(bist_locked), 1);
        check("t4_word_restart", 32'(bist_word_cnt), 1);
        check("t4_err_held", 32'(bist_err_cnt), 4);

        // 5: sync failure after 64 non-matching words
        enable();
        for (int k = 0; k < 64; k++) begin
            xfer(32'h0000_0000);
            if (k == 62) check("t5_no_fail_63", 32'(bist_sync_fail), 0);
        end
        check("t5_sync_fail", 32'(bist_sync_fail), 1);
        check("t5_unlocked", 32'(bist_locked), 0);
        xfer(wf(16'h0010));
        check("t5_lock", 32'(bist_locked), 1);
        check("t5_fail_sticky", 32'(bist_sync_fail), 1);
        enable();
        idle(1);
        check("t5_fail_cleared", 32'(bist_sync_fail), 0);

        // mixed traffic, register change mid-run
        for (int i = 0; i < 60; i++) begin
            int r;
            @(negedge clk);
            if (i == 30) set_regs(12'h010, 8'h03, 12'h040);
            r = int'($urandom_range(0, 9));
            i2si_xfc  = (r < 6);
            i2si_data = (r < 4) ? wf(m_lock ? m_exp : start16()) : $urandom;
        end
        @(negedge clk) i2si_xfc = 1'b0;

        // limit below start: constant stream passes
        set_regs(12'h050, 8'h04, 12'h020);
        enable();
        repeat (5) xfer(wf(16'h0050));
        check("tc_err_cnt", 32'(bist_err_cnt), 0);
        check("tc_word_cnt", 32'(bist_word_cnt), 5);
        check("tc_locked", 32'(bist_locked), 1);

        // 6: saturation, disable with xfc, reset with xfc
        set_regs(12'h010, 8'h04, 12'h020);
        enable();
        xfer(wf(16'h0010));
        for (int k = 1; k <= 24; k++)
            xfer(((k - 1) % 4 < 3) ? (wf(saw(k)) ^ 32'h8000_0000) : wf(saw(k)));
        check("t6_err_cnt", 32'(bist_err_cnt), 18);
        check("t6_word_cnt", 32'(bist_word_cnt), 25);
        check("t6_err_sat_4b", 32'(err_cnt_s), 15);
        check("t6_word_sat_4b", 32'(word_cnt_s), 15);
        check("t6_locked", 32'(bist_locked), 1);
        @(negedge clk);
        chk_en = 1'b0; i2si_xfc = 1'b1; i2si_data = 32'h1234_5678;
        @(negedge clk) i2si_xfc = 1'b0;
        check("t6_dis_unlocked", 32'(bist_locked), 0);
        check("t6_dis_no_err", 32'(bist_err), 0);
        check("t6_dis_err_held", 32'(bist_err_cnt), 18);
        check("t6_dis_word_held", 32'(bist_word_cnt), 25);
        enable();
        xfer(wf(16'h0010));
        xfer(32'h0000_0014);
        check("t6_pre_rst_err", 32'(bist_err_cnt), 1);
        @(negedge clk);
        rst = 1'b1; i2si_xfc = 1'b1; i2si_data = wf(16'h0018);
        #1;
        check("t6_rst_locked", 32'(bist_locked), 0);
        check("t6_rst_err", 32'(bist_err), 0);
        check("t6_rst_err_cnt", 32'(bist_err_cnt), 0);
        check("t6_rst_word_cnt", 32'(bist_word_cnt), 0);
        @(negedge clk);
        rst = 1'b0; i2si_xfc = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
